// File: rtl/match_referee_if.sv
// Bus between match_referee and the player/display side.
// With REFEREE_PAUSE_EN defined the bus also carries a pause level.
interface match_referee_if #(
  parameter int TW = 6
);
  logic          start;
  logic [1:0]    health1;
  logic [1:0]    health2;
`ifdef REFEREE_PAUSE_EN
  logic          pause;
`endif
  logic          actionEnable;
  logic          isGameOver;
  logic [1:0]    winner;
  logic [TW-1:0] round_time;

  modport master (
    input  start, health1, health2,
`ifdef REFEREE_PAUSE_EN
    input  pause,
`endif
    output actionEnable, isGameOver, winner, round_time
  );

  modport slave (
    output start, health1, health2,
`ifdef REFEREE_PAUSE_EN
    output pause,
`endif
    input  actionEnable, isGameOver, winner, round_time
  );
endinterface

// File: rtl/match_referee.sv
// Match control: action strobe generation, round timer, KO/timeout judging.
// Optional macro REFEREE_PAUSE_EN adds a pause input that freezes the timers.
module match_referee #(
  parameter int TICK_DIV    = 4,
  parameter int ENABLE_HIGH = 2,
  parameter int ROUND_TICKS = 60,
  parameter int TW          = 6
) (
  input logic clk,
  input logic reset,
  match_referee_if.master bus
);

  localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [TW-1:0] round_time;
  logic          action_enable;
  logic          game_over;
  logic [1:0]    winner;

  logic [DW-1:0] div_nxt;
  logic          div_last;
  logic          ko;
  logic          timeout;
  logic          paused;

  // Timeout verdict: higher remaining health wins, equal is a draw.
  function automatic logic [1:0] timeout_winner(input logic [1:0] h1, input logic [1:0] h2);
    if (h1 > h2)      return 2'b01;
    else if (h1 < h2) return 2'b10;
    else              return 2'b11;
  endfunction

  // KO verdict: bit 1 flags player 1 down, bit 0 flags player 2 down.
  function automatic logic [1:0] ko_winner(input logic [1:0] h1, input logic [1:0] h2);
    return {h1 == 2'b00, h2 == 2'b00};
  endfunction

  always_comb begin
    div_last = (div_cnt == DW'(TICK_DIV - 1));
    div_nxt  = div_last ? '0 : div_cnt + DW'(1);
    ko       = (bus.health1 == 2'b00) || (bus.health2 == 2'b00);
    timeout  = div_last && (round_time == TW'(1));
`ifdef REFEREE_PAUSE_EN
    paused   = bus.pause;
`else
    paused   = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      div_cnt       <= '0;
      round_time    <= TW'(ROUND_TICKS);
      action_enable <= 1'b0;
      game_over     <= 1'b0;
      winner        <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state         <= PLAY;
            div_cnt       <= '0;
            action_enable <= 1'b1;
          end
        end
        PLAY: begin
          // KO freezes the counters; a timeout lands them on their final values.
          if (ko) begin
            state         <= OVER;
            game_over     <= 1'b1;
            action_enable <= 1'b0;
            winner        <= ko_winner(bus.health1, bus.health2);
          end else if (paused) begin
            action_enable <= 1'b0;
          end else if (timeout) begin
            state         <= OVER;
            game_over     <= 1'b1;
            action_enable <= 1'b0;
            div_cnt       <= div_nxt;
            round_time    <= '0;
            winner        <= timeout_winner(bus.health1, bus.health2);
          end else begin
            div_cnt       <= div_nxt;
            action_enable <= (div_nxt < DW'(ENABLE_HIGH));
            if (div_last)
              round_time <= round_time - TW'(1);
          end
        end
        default: begin
          state <= OVER;
        end
      endcase
    end
  end

  assign bus.actionEnable = action_enable;
  assign bus.isGameOver   = game_over;
  assign bus.winner       = winner;
  assign bus.round_time   = round_time;

endmodule

// File: tb/tb_match_referee.sv
// Bench for match_referee: vector table, directed corner sequences and a
// randomized run checked against a cycle-count based model of the match.
module tb_match_referee;

  localparam int TD = 4;
  localparam int EH = 2;
  localparam int RT = 60;
  localparam int TW = 6;

  logic clk;
  logic reset;
  logic       start;
  logic [1:0] h1;
  logic [1:0] h2;

  int total = 0;
  int bad   = 0;

  match_referee_if #(.TW(TW)) bus ();

  assign bus.start   = start;
  assign bus.health1 = h1;
  assign bus.health2 = h2;
`ifdef REFEREE_PAUSE_EN
  assign bus.pause   = 1'b0;
`endif

  match_referee #(
    .TICK_DIV(TD), .ENABLE_HIGH(EH), .ROUND_TICKS(RT), .TW(TW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: match progress expressed as edges elapsed since the start edge.
  int m_state;  // 0 idle, 1 playing, 2 over
  int m_t;
  int m_win;

  task automatic model_reset();
    m_state = 0;
    m_t     = 0;
    m_win   = 0;
  endtask

  task automatic model_edge();
    case (m_state)
      0: if (start) begin m_state = 1; m_t = 0; end
      1: begin
        if (h1 == 0 || h2 == 0) begin
          m_state = 2;
          m_win = (h1 == 0 && h2 == 0) ? 3 : (h2 == 0) ? 1 : 2;
        end else begin
          m_t++;
          if (m_t == TD * RT) begin
            m_state = 2;
            m_win = (h1 > h2) ? 1 : (h1 < h2) ? 2 : 3;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".actionEnable"}, int'(bus.actionEnable), (m_state == 1 && (m_t % TD) < EH) ? 1 : 0);
    chk({tag, ".isGameOver"},   int'(bus.isGameOver),   (m_state == 2) ? 1 : 0);
    chk({tag, ".winner"},       int'(bus.winner),       (m_state == 2) ? m_win : 0);
    chk({tag, ".round_time"},   int'(bus.round_time),   RT - m_t / TD);
  endtask

  task automatic chk_out(input string tag, input int ae, input int go, input int w, input int rt);
    chk({tag, ".actionEnable"}, int'(bus.actionEnable), ae);
    chk({tag, ".isGameOver"},   int'(bus.isGameOver),   go);
    chk({tag, ".winner"},       int'(bus.winner),       w);
    chk({tag, ".round_time"},   int'(bus.round_time),   rt);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    h1 = 2'd3;
    h2 = 2'd3;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic       st;
    logic [1:0] vh1;
    logic [1:0] vh2;
    int         ae;
    int         go;
    int         w;
    int         rt;
  } vec_t;

  vec_t tbl[9];

  task automatic start_match(input logic [1:0] a, input logic [1:0] b);
    reset_dut();
    start = 1'b1; h1 = a; h2 = b;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    h1 = 2'd3;
    h2 = 2'd3;
    model_reset();

    tbl[0] = '{1'b1, 2'd3, 2'd3, 1, 0, 0, 60};
    tbl[1] = '{1'b0, 2'd3, 2'd3, 1, 0, 0, 60};
    tbl[2] = '{1'b0, 2'd3, 2'd3, 0, 0, 0, 60};
    tbl[3] = '{1'b0, 2'd3, 2'd3, 0, 0, 0, 60};
    tbl[4] = '{1'b0, 2'd3, 2'd3, 1, 0, 0, 59};
    tbl[5] = '{1'b0, 2'd2, 2'd3, 1, 0, 0, 59};
    tbl[6] = '{1'b0, 2'd2, 2'd0, 0, 1, 1, 59};
    tbl[7] = '{1'b0, 2'd0, 2'd0, 0, 1, 1, 59};
    tbl[8] = '{1'b1, 2'd3, 2'd3, 0, 1, 1, 59};

    // Reset values
    reset_dut();
    #1;
    chk_out("reset", 0, 0, 0, 60);

    // Strobe pattern, player 2 KO, sticky OVER
    for (int i = 0; i < 9; i++) begin
      start = tbl[i].st; h1 = tbl[i].vh1; h2 = tbl[i].vh2;
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].ae, tbl[i].go, tbl[i].w, tbl[i].rt);
    end
    repeat (3) step();
    chk_out("sticky", 0, 1, 1, 59);

    // Double KO
    start_match(2'd3, 2'd3);
    repeat (2) step();
    h1 = 2'd0; h2 = 2'd0;
    step();
    chk_out("double_ko", 0, 1, 3, 60);

    // Timeout, player 1 ahead
    start_match(2'd3, 2'd1);
    repeat (TD * RT - 1) step();
    chk_out("pre_timeout", 0, 0, 0, 1);
    step();
    chk_out("timeout_p1", 0, 1, 1, 0);
    h1 = 2'd0;
    step();
    chk_out("timeout_hold", 0, 1, 1, 0);

    // Timeout, equal healths
    start_match(2'd2, 2'd2);
    repeat (TD * RT) step();
    chk_out("timeout_draw", 0, 1, 3, 0);

    // KO on the final wrap edge overrides the draw comparison
    start_match(2'd3, 2'd3);
    repeat (TD * RT - 1) step();
    h2 = 2'd0;
    step();
    chk("ko_wrap.isGameOver", int'(bus.isGameOver), 1);
    chk("ko_wrap.winner", int'(bus.winner), 1);
    chk_model("ko_wrap");

    // Asynchronous reset between edges mid-PLAY
    start_match(2'd3, 2'd3);
    repeat (5) step();
    chk_out("pre_areset", 1, 0, 0, 59);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk_out("areset", 0, 0, 0, 60);
    @(negedge clk);
    reset = 1'b1;

    // Randomized matches against the model
    for (int r = 0; r < 20; r++) begin
      int ko_on;
      reset_dut();
      ko_on = $urandom_range(0, 2);
      for (int c = 0; c < 300; c++) begin
        start = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 9) == 0) h1 = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 9) == 0) h2 = 2'($urandom_range(1, 3));
        if (ko_on != 0 && $urandom_range(0, 149) == 0) h1 = 2'd0;
        if (ko_on != 0 && $urandom_range(0, 149) == 0) h2 = 2'd0;
        step();
        chk_model($sformatf("rnd%0d_%0d", r, c));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
